// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq
// Brief    : Multi-cycle multiply/divide unit owning the HI/LO registers.
// Revision : 1.0  initial release
// ============================================================================
module mdu_seq #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_mult_cnt = 4'(MULT_LAT);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_LAT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_is_div;
    logic        r_is_unsigned;

    logic        w_idle_start;
    logic        w_start_md;
    logic        w_done;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_idle_start = (r_state == IDLE) && start;
    assign w_start_md   = w_idle_start && (op[2] == 1'b0);
    assign w_done       = (r_state == BUSY) && (r_cnt == 4'd1);
    assign busy         = (r_state == BUSY);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_prod   = r_is_unsigned ? w_prod_u : w_prod_s;

    // Sign-magnitude divide: 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_a_neg    = ~r_is_unsigned & r_a[31];
    assign w_b_neg    = ~r_is_unsigned & r_b[31];
    assign w_div_zero = (r_b == 32'd0);
    assign w_abs_a    = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_abs_b    = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_divisor  = w_div_zero ? 32'd1 : w_abs_b;
    assign w_q_mag    = w_abs_a / w_divisor;
    assign w_r_mag    = w_abs_a % w_divisor;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_md) w_next_state = BUSY;
            BUSY:    if (w_done)     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt         <= 4'd0;
            r_a           <= 32'd0;
            r_b           <= 32'd0;
            r_is_div      <= 1'b0;
            r_is_unsigned <= 1'b0;
            hi            <= 32'd0;
            lo            <= 32'd0;
        end else if (w_start_md) begin
            r_a           <= inA;
            r_b           <= inB;
            r_is_div      <= op[1];
            r_is_unsigned <= op[0];
            r_cnt         <= op[1] ? c_div_cnt : c_mult_cnt;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 4'd1;
            if (w_done) begin
                if (!r_is_div) begin
                    hi <= w_prod[63:32];
                    lo <= w_prod[31:0];
                end else if (!w_div_zero) begin
                    hi <= w_rem;
                    lo <= w_quot;
                end
            end
        end else if (w_idle_start) begin
            if (op == 3'b100) hi <= inA;
            if (op == 3'b101) lo <= inA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_seq
// Brief    : Scoreboard bench for mdu_seq; completions checked on busy fall.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_seq;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        bit          wr;
    } sb_t;

    sb_t         q_sb[$];
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;
    int          n_cmp  = 0;
    int          n_err  = 0;
    bit          mon_en = 1'b0;
    bit          prev_busy = 1'b0;
    int          busy_cycles = 0;

    mdu_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .inA   (inA),
        .inB   (inB),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference results from 64-bit integer arithmetic.
    function automatic sb_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        sb_t    e;
        longint x, y, p, qt, rm;
        e.wr  = 1'b1;
        e.lat = o[1] ? DIV_LAT : MULT_LAT;
        e.hi  = 32'd0;
        e.lo  = 32'd0;
        if (o[0]) begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end else begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end
        if (!o[1]) begin
            p    = x * y;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.wr = 1'b0;
        end else begin
            qt   = x / y;
            rm   = x % y;
            e.lo = qt[31:0];
            e.hi = rm[31:0];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit acc);
        start = 1'b1;
        op    = o;
        inA   = a;
        inB   = b;
        if (acc && !o[2]) q_sb.push_back(model(o, a, b));
        tick();
        start = 1'b0;
        inA   = $urandom;
        inB   = $urandom;
        if (acc) begin
            if (o == 3'b100) cur_hi = a;
            if (o == 3'b101) cur_lo = a;
            if (!o[2]) chk_eq("busy_rise", 32'(busy), 32'd1);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        if (busy) chk_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset) begin
                prev_busy   = 1'b0;
                busy_cycles = 0;
            end else begin
                if (busy) begin
                    busy_cycles++;
                end else if (prev_busy) begin
                    if (q_sb.size() == 0) begin
                        chk_eq("spurious_done", 32'(busy_cycles), 32'd0);
                    end else begin
                        sb_t e;
                        e = q_sb.pop_front();
                        chk_eq("latency", 32'(busy_cycles), 32'(e.lat));
                        if (e.wr) begin
                            cur_hi = e.hi;
                            cur_lo = e.lo;
                        end
                    end
                    busy_cycles = 0;
                end
                chk_eq("hi", hi, cur_hi);
                chk_eq("lo", lo, cur_lo);
                prev_busy = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        inA   = 32'd0;
        inB   = 32'd0;
        repeat (3) tick();
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_hi", hi, 32'd0);
        chk_eq("rst_lo", lo, 32'd0);

        // Start on the very first edge out of reset.
        reset  = 1'b1;
        mon_en = 1'b1;
        issue(3'b000, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_idle();
        chk_eq("mult_hi", hi, 32'hFFFF_FFFF);
        chk_eq("mult_lo", lo, 32'hFFFF_FFFE);
        issue(3'b001, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_idle();
        chk_eq("multu_hi", hi, 32'h0000_0001);
        chk_eq("multu_lo", lo, 32'hFFFF_FFFE);

        issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        chk_eq("div_lo", lo, 32'hFFFF_FFFD);
        chk_eq("div_hi", hi, 32'hFFFF_FFFF);
        issue(3'b011, 32'd7, 32'd2, 1'b1);
        wait_idle();
        chk_eq("divu_lo", lo, 32'd3);
        chk_eq("divu_hi", hi, 32'd1);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        chk_eq("divovf_lo", lo, 32'h8000_0000);
        chk_eq("divovf_hi", hi, 32'd0);

        issue(3'b100, 32'h1234, 32'hAAAA_AAAA, 1'b1);
        chk_eq("mthi_busy", 32'(busy), 32'd0);
        issue(3'b101, 32'h5678, 32'h5555_5555, 1'b1);
        issue(3'b011, 32'd99, 32'd0, 1'b1);
        wait_idle();
        chk_eq("dz_hi", hi, 32'h1234);
        chk_eq("dz_lo", lo, 32'h5678);

        issue(3'b110, 32'hDEAD_BEEF, 32'd1, 1'b0);
        chk_eq("nop6_busy", 32'(busy), 32'd0);
        issue(3'b111, 32'hDEAD_BEEF, 32'd1, 1'b0);
        chk_eq("nop7_busy", 32'(busy), 32'd0);

        // Requests while busy must be dropped.
        issue(3'b000, 32'd3, 32'd4, 1'b1);
        issue(3'b101, 32'hDEAD, 32'd0, 1'b0);
        issue(3'b011, 32'd9, 32'd2, 1'b0);
        wait_idle();
        chk_eq("ign_lo", lo, 32'd12);
        chk_eq("ign_hi", hi, 32'd0);

        // Back-to-back with no dead cycle.
        issue(3'b001, 32'd2, 32'd3, 1'b1);
        wait_idle();
        chk_eq("b2b_lo0", lo, 32'd6);
        issue(3'b011, 32'd100, 32'd7, 1'b1);
        wait_idle();
        chk_eq("b2b_lo1", lo, 32'd14);
        chk_eq("b2b_hi1", hi, 32'd2);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i == 2) rb = 32'd0;
            if (i >= 4) rb = rb >> 27;
            issue(ro, ra, rb, 1'b1);
            wait_idle();
        end

        // Reset in the third busy cycle discards the operation.
        issue(3'b000, 32'h0001_0000, 32'h0001_0000, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        q_sb.delete();
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        chk_eq("midrst_busy", 32'(busy), 32'd0);
        chk_eq("midrst_hi", hi, 32'd0);
        chk_eq("midrst_lo", lo, 32'd0);
        tick();
        reset = 1'b1;
        repeat (12) tick();

        chk_eq("sb_empty", 32'(q_sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
